// File: rtl/modn_updown_counter.sv
// Mod-N up/down counter with prescaler, synchronous load, and tc/wrap cascade outputs.
// Optional registered BCD image of the count when MODN_BCD_EN is defined.
module modn_updown_counter #(
    parameter int MODULUS  = 100,
    parameter int WIDTH    = $clog2(MODULUS),
    parameter int PRESCALE = 1
`ifdef MODN_BCD_EN
    ,
    parameter int BCD_DIG  = 2
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
`ifdef MODN_BCD_EN
    ,
    output logic [4*BCD_DIG-1:0] bcd
`endif
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    ps_q, ps_d;
    logic             wrap_q, wrap_d;
    logic             lerr_q, lerr_d;
    logic             step;
    logic             at_end;
    logic             load_bad;

    assign step     = en & (ps_q == PS_LAST);
    assign at_end   = up_dn ? (count_q == CNT_MAX) : (count_q == '0);
    assign load_bad = ({1'b0, load_val} >= MOD_EXT);

`ifdef MODN_BCD_EN
    localparam int BW = 4 * BCD_DIG;

    logic [BW-1:0] bcd_q, bcd_d;

    // Double-dabble conversion; only used for loads and the down-wrap constant.
    function automatic logic [BW-1:0] bin2bcd(input logic [WIDTH-1:0] v);
        logic [BW-1:0] r;
        r = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            for (int d = 0; d < BCD_DIG; d++) begin
                if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
            end
            r = {r[BW-2:0], v[i]};
        end
        return r;
    endfunction

    // Decade increment with ripple carry between digits.
    function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int d = 0; d < BCD_DIG; d++) begin
            if (c) begin
                if (r[4*d +: 4] == 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = r[4*d +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Decade decrement with ripple borrow between digits.
    function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          b;
        r = v;
        b = 1'b1;
        for (int d = 0; d < BCD_DIG; d++) begin
            if (b) begin
                if (r[4*d +: 4] == 4'd0) begin
                    r[4*d +: 4] = 4'd9;
                end else begin
                    r[4*d +: 4] = r[4*d +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction
`endif

    // Next-state: load beats step, step beats hold.
    always_comb begin
        count_d = count_q;
        ps_d    = ps_q;
        wrap_d  = 1'b0;
        lerr_d  = 1'b0;
`ifdef MODN_BCD_EN
        bcd_d   = bcd_q;
`endif
        if (load) begin
            ps_d = '0;
            if (load_bad) begin
                count_d = '0;
                lerr_d  = 1'b1;
`ifdef MODN_BCD_EN
                bcd_d   = '0;
`endif
            end else begin
                count_d = load_val;
`ifdef MODN_BCD_EN
                bcd_d   = bin2bcd(load_val);
`endif
            end
        end else if (step) begin
            ps_d   = '0;
            wrap_d = at_end;
            if (up_dn) begin
                count_d = at_end ? '0 : count_q + 1'b1;
`ifdef MODN_BCD_EN
                bcd_d   = at_end ? '0 : bcd_inc(bcd_q);
`endif
            end else begin
                count_d = at_end ? CNT_MAX : count_q - 1'b1;
`ifdef MODN_BCD_EN
                bcd_d   = at_end ? bin2bcd(CNT_MAX) : bcd_dec(bcd_q);
`endif
            end
        end else if (en) begin
            ps_d = ps_q + 1'b1;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            ps_q    <= '0;
            wrap_q  <= 1'b0;
            lerr_q  <= 1'b0;
`ifdef MODN_BCD_EN
            bcd_q   <= '0;
`endif
        end else begin
            count_q <= count_d;
            ps_q    <= ps_d;
            wrap_q  <= wrap_d;
            lerr_q  <= lerr_d;
`ifdef MODN_BCD_EN
            bcd_q   <= bcd_d;
`endif
        end
    end

    assign count    = count_q;
    assign tc       = step & at_end;
    assign wrap     = wrap_q;
    assign load_err = lerr_q;
`ifdef MODN_BCD_EN
    assign bcd      = bcd_q;
`endif

endmodule

// File: tb/tb_modn_updown_counter.sv
// Bench for modn_updown_counter: three instances (M100/P1, M100/P4, M10/P1)
// share one input stream and are checked against an arithmetic model.
module tb_modn_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [6:0] load_val = '0;

    logic [6:0] cnt0, cnt1;
    logic [3:0] cnt2;
    logic [2:0] tc_o, wrap_o, lerr_o;
`ifdef MODN_BCD_EN
    logic [7:0] bcd0, bcd1, bcd2;
`endif

    int vectors = 0;
    int miscompares = 0;

    int modv[3] = '{100, 100, 10};
    int psv[3]  = '{1, 4, 1};
    int mc[3];
    int mp[3];
    int mw[3];
    int ml[3];

    always #5 clk = ~clk;

    modn_updown_counter #(.MODULUS(100), .PRESCALE(1)) u0 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(cnt0), .tc(tc_o[0]), .wrap(wrap_o[0]),
        .load_err(lerr_o[0])
`ifdef MODN_BCD_EN
        , .bcd(bcd0)
`endif
    );

    modn_updown_counter #(.MODULUS(100), .PRESCALE(4)) u1 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(cnt1), .tc(tc_o[1]), .wrap(wrap_o[1]),
        .load_err(lerr_o[1])
`ifdef MODN_BCD_EN
        , .bcd(bcd1)
`endif
    );

    modn_updown_counter #(.MODULUS(10), .PRESCALE(1)) u2 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val[3:0]), .count(cnt2), .tc(tc_o[2]),
        .wrap(wrap_o[2]), .load_err(lerr_o[2])
`ifdef MODN_BCD_EN
        , .bcd(bcd2)
`endif
    );

    task automatic chk(input string tag, input int i, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, i, obs, exp);
        end
    endtask

    function automatic int dut_count(input int i);
        if (i == 0) return int'(cnt0);
        if (i == 1) return int'(cnt1);
        return int'(cnt2);
    endfunction

`ifdef MODN_BCD_EN
    function automatic int dut_bcd(input int i);
        if (i == 0) return int'(bcd0);
        if (i == 1) return int'(bcd1);
        return int'(bcd2);
    endfunction
`endif

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mc[i] = 0; mp[i] = 0; mw[i] = 0; ml[i] = 0;
        end
    endtask

    // Would the next enabled step leave the 0..M-1 range?
    function automatic int exp_tc(input int i);
        int nxt;
        nxt = up_dn ? mc[i] + 1 : mc[i] - 1;
        return (en && mp[i] == psv[i] - 1 && (nxt < 0 || nxt >= modv[i])) ? 1 : 0;
    endfunction

    task automatic model_edge();
        int lv, nxt;
        for (int i = 0; i < 3; i++) begin
            lv = (i == 2) ? int'(load_val) % 16 : int'(load_val);
            mw[i] = 0;
            ml[i] = 0;
            if (load) begin
                ml[i] = (lv >= modv[i]) ? 1 : 0;
                mc[i] = (lv >= modv[i]) ? 0 : lv;
                mp[i] = 0;
            end else if (en) begin
                mp[i]++;
                if (mp[i] == psv[i]) begin
                    mp[i] = 0;
                    nxt = up_dn ? mc[i] + 1 : mc[i] - 1;
                    mw[i] = (nxt < 0 || nxt >= modv[i]) ? 1 : 0;
                    mc[i] = (nxt + modv[i]) % modv[i];
                end
            end
        end
    endtask

    task automatic check_regs();
        for (int i = 0; i < 3; i++) begin
            chk("count", i, dut_count(i), mc[i]);
            chk("wrap", i, int'(wrap_o[i]), mw[i]);
            chk("load_err", i, int'(lerr_o[i]), ml[i]);
`ifdef MODN_BCD_EN
            chk("bcd", i, dut_bcd(i), ((mc[i] / 10) << 4) | (mc[i] % 10));
`endif
        end
    endtask

    task automatic cycle();
        #1;
        for (int i = 0; i < 3; i++) chk("tc", i, int'(tc_o[i]), exp_tc(i));
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
    endtask

    initial begin
        // reset state
        model_reset();
        #12;
        check_regs();
        rst = 1'b0;
        #1;

        // count up through a full wrap
        en = 1'b1; up_dn = 1'b1;
        for (int k = 0; k < 100; k++) cycle();
        chk("wrap99to0", 0, dut_count(0), 0);

        // turn around at zero
        up_dn = 1'b0;
        cycle();
        chk("down0to99", 0, dut_count(0), 99);
        cycle();
        cycle();

        // en gap mid-prescale
        up_dn = 1'b1;
        cycle();
        en = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        en = 1'b1;
        for (int k = 0; k < 6; k++) cycle();

        // loads
        load = 1'b1; load_val = 7'd57;
        cycle();
        chk("load57", 0, dut_count(0), 57);
        load_val = 7'd120;
        cycle();
        chk("load120_err", 0, int'(lerr_o[0]), 1);
        load = 1'b0;
        cycle();
        chk("load_err_pulse", 0, int'(lerr_o[0]), 0);

        // async reset at count 42
        load = 1'b1; load_val = 7'd42;
        cycle();
        load = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        check_regs();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) cycle();

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            en       = ($urandom_range(0, 3) != 0);
            up_dn    = ($urandom_range(0, 7) < 5);
            load     = ($urandom_range(0, 15) == 0);
            load_val = 7'($urandom_range(0, 127));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
